// File: rtl/ddr_app_model.sv
`default_nettype none
//==============================================================================
// Module   : ddr_app_model
// Desc     : Block-RAM backed responder for the DDR controller app interface.
//            Optional random ready stalls when DDR_MODEL_STALL_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
module ddr_app_model #(
    parameter int ADDR_BITS    = 10,
    parameter int CALIB_CYCLES = 64,
    parameter int READ_LATENCY = 4,
    parameter int WFIFO_LOG2   = 6
) (
    input  logic         clk_x1,
    input  logic         rst,
    input  logic [26:0]  app_addr,
    input  logic         app_cmd_en,
    input  logic [2:0]   app_cmd,
    output logic         app_cmd_rdy,
    input  logic [5:0]   app_burst_number,
    input  logic         app_wren,
    input  logic         app_data_end,
    input  logic [127:0] app_data,
    output logic         app_data_rdy,
    output logic         app_rdata_valid,
    output logic         app_rdata_end,
    output logic [127:0] app_rdata,
    output logic         init_calib_complete,
    output logic         wr_overflow
);

    localparam int            c_CNT_W      = 16;
    localparam int            c_DEPTH      = 1 << WFIFO_LOG2;
    localparam logic [c_CNT_W-1:0] c_CALIB_LAST = c_CNT_W'(CALIB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST    = c_CNT_W'(READ_LATENCY - 2);
    localparam logic [WFIFO_LOG2:0] c_FIFO_FULL = {1'b1, {WFIFO_LOG2{1'b0}}};
    localparam logic [2:0]    c_CMD_WR     = 3'h0;
    localparam logic [2:0]    c_CMD_RD     = 3'h1;

    localparam logic [2:0] c_ST_INIT     = 3'd0;
    localparam logic [2:0] c_ST_IDLE     = 3'd1;
    localparam logic [2:0] c_ST_WRITE    = 3'd2;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_RD_BURST = 3'd4;

    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ADDR_BITS-1:0] r_idx;
    logic [6:0]           r_left;
    logic                 r_calib;
    logic                 r_issue_d;
    logic                 r_valid;
    logic [127:0]         r_rdata;
    logic [127:0]         r_ram_q;
    logic [127:0]         r_mem [0:(1 << ADDR_BITS)-1];

    logic [127:0]          r_fifo [0:c_DEPTH-1];
    logic [WFIFO_LOG2-1:0] r_wptr;
    logic [WFIFO_LOG2-1:0] r_rptr;
    logic [WFIFO_LOG2:0]   r_count;
    logic                  r_data_rdy;
    logic                  r_overflow;

    logic                  w_cmd_acc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_issue;
    logic [WFIFO_LOG2:0]   w_count_next;
    logic [127:0]          w_fifo_head;
    logic                  w_unused;

`ifdef DDR_MODEL_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign app_cmd_rdy  = (r_state == c_ST_IDLE) & ~r_lfsr[0];
    assign app_data_rdy = r_data_rdy & ~r_lfsr[1];
`else
    assign app_cmd_rdy  = (r_state == c_ST_IDLE);
    assign app_data_rdy = r_data_rdy;
`endif

    assign w_cmd_acc    = app_cmd_en & app_cmd_rdy;
    assign w_push       = app_wren & app_data_rdy;
    assign w_pop        = (r_state == c_ST_WRITE) && (r_count != '0);
    assign w_fifo_head  = r_fifo[r_rptr];
    assign w_count_next = r_count + {{WFIFO_LOG2{1'b0}}, w_push} - {{WFIFO_LOG2{1'b0}}, w_pop};
    // Read addresses are issued one cycle ahead of the beat to cover the RAM output stage.
    assign w_rd_issue   = ((r_state == c_ST_RD_WAIT) && (r_cnt == c_RD_LAST)) ||
                          ((r_state == c_ST_RD_BURST) && (r_left != '0));
    assign w_unused     = ^{app_data_end, app_addr[26:ADDR_BITS+3], app_addr[2:0]};

    assign app_rdata_valid     = r_valid;
    assign app_rdata_end       = r_valid;
    assign app_rdata           = r_rdata;
    assign init_calib_complete = r_calib;
    assign wr_overflow         = r_overflow;

    always_ff @(posedge clk_x1) begin
        if (w_pop) begin
            r_mem[r_idx] <= w_fifo_head;
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[r_idx];
        end
        if (w_push) begin
            r_fifo[r_wptr] <= app_data;
        end
    end

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_data_rdy <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_data_rdy <= (w_count_next != c_FIFO_FULL);
            if (app_wren && !app_data_rdy) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_INIT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_left    <= '0;
            r_calib   <= 1'b0;
            r_issue_d <= 1'b0;
            r_valid   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_issue_d <= w_rd_issue;
            r_valid   <= r_issue_d;
            if (r_issue_d) begin
                r_rdata <= r_ram_q;
            end
            case (r_state)
                c_ST_INIT: begin
                    if (r_cnt == c_CALIB_LAST) begin
                        r_calib <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (w_cmd_acc) begin
                        r_idx  <= app_addr[ADDR_BITS+2:3];
                        r_left <= {1'b0, app_burst_number} + 7'd1;
                        r_cnt  <= '0;
                        if (app_cmd == c_CMD_WR) begin
                            r_state <= c_ST_WRITE;
                        end else if (app_cmd == c_CMD_RD) begin
                            r_state <= c_ST_RD_WAIT;
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (w_pop) begin
                        r_idx  <= r_idx + 1'b1;
                        r_left <= r_left - 1'b1;
                        if (r_left == 7'd1) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_RD_WAIT: begin
                    if (r_cnt == c_RD_LAST) begin
                        r_idx   <= r_idx + 1'b1;
                        r_left  <= r_left - 1'b1;
                        r_state <= c_ST_RD_BURST;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RD_BURST: begin
                    if (r_left != '0) begin
                        r_idx  <= r_idx + 1'b1;
                        r_left <= r_left - 1'b1;
                    end else if (!r_issue_d) begin
                        // Last beat has left the output register; release the command port.
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_app_model.sv
`default_nettype none
//==============================================================================
// Module   : tb_ddr_app_model
// Desc     : Randomised self-checking bench for ddr_app_model against a
//            transaction-level memory/FIFO model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ddr_app_model;

    localparam int c_L     = 4;
    localparam int c_CALIB = 64;
    localparam int c_WORDS = 1024;

    logic         clk_x1 = 1'b0;
    logic         rst = 1'b1;
    logic [26:0]  app_addr = '0;
    logic         app_cmd_en = 1'b0;
    logic [2:0]   app_cmd = '0;
    logic         app_cmd_rdy;
    logic [5:0]   app_burst_number = '0;
    logic         app_wren = 1'b0;
    logic         app_data_end = 1'b0;
    logic [127:0] app_data = '0;
    logic         app_data_rdy;
    logic         app_rdata_valid;
    logic         app_rdata_end;
    logic [127:0] app_rdata;
    logic         init_calib_complete;
    logic         wr_overflow;

    ddr_app_model u_dut (
        .clk_x1              (clk_x1),
        .rst                 (rst),
        .app_addr            (app_addr),
        .app_cmd_en          (app_cmd_en),
        .app_cmd             (app_cmd),
        .app_cmd_rdy         (app_cmd_rdy),
        .app_burst_number    (app_burst_number),
        .app_wren            (app_wren),
        .app_data_end        (app_data_end),
        .app_data            (app_data),
        .app_data_rdy        (app_data_rdy),
        .app_rdata_valid     (app_rdata_valid),
        .app_rdata_end       (app_rdata_end),
        .app_rdata           (app_rdata),
        .init_calib_complete (init_calib_complete),
        .wr_overflow         (wr_overflow)
    );

    always #5 clk_x1 = ~clk_x1;

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           rel_cyc = 0;
    bit           in_reset = 1'b1;
    bit           ovf_set = 1'b0;
    int           ovf_cyc = 0;
    logic [127:0] mem_m [c_WORDS];
    logic [127:0] wq [$];
    exp_t         exp_q [$];
    logic [127:0] cap_q [$];
    int           cap_cyc [$];
    int           log_idx [$];
    int           log_n [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Per-cycle comparison of the DUT against the model's expectations.
    initial begin
        int since;
        forever begin
            @(posedge clk_x1);
            cyc++;
            #1;
            if (in_reset) begin
                chk("reset_valid", app_rdata_valid, 0);
                chk("reset_end", app_rdata_end, 0);
                chk("reset_cmd_rdy", app_cmd_rdy, 0);
                chk("reset_data_rdy", app_data_rdy, 0);
                chk("reset_calib", init_calib_complete, 0);
                chk("reset_overflow", wr_overflow, 0);
            end else begin
                since = cyc - rel_cyc;
                chk("calib", init_calib_complete, since >= c_CALIB);
                if (since < c_CALIB) chk("cmd_rdy_during_calib", app_cmd_rdy, 0);
                if (since == c_CALIB) chk("cmd_rdy_at_calib", app_cmd_rdy, 1);
                chk("overflow", wr_overflow, ovf_set && (cyc >= ovf_cyc));
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    chk("rd_valid", app_rdata_valid, 1);
                    chk("rd_end", app_rdata_end, 1);
                    chk("rd_data", app_rdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end else begin
                    chk("rd_valid_idle", app_rdata_valid, 0);
                    chk("rd_end_idle", app_rdata_end, 0);
                end
                if (app_rdata_valid) begin
                    chk("cmd_rdy_in_burst", app_cmd_rdy, 0);
                    cap_q.push_back(app_rdata);
                    cap_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic do_write(input logic [26:0] addr, input int burst,
                            input logic [127:0] d[$], input int pre);
        int total;
        int pushed;
        int guard;
        int idx;
        bit cmd_done;
        bit go_cmd;
        bit go_push;
        total = d.size();
        pushed = 0;
        guard = 0;
        cmd_done = 1'b0;
        while ((!cmd_done || pushed < total) && guard < 500) begin
            @(negedge clk_x1);
            guard++;
            app_cmd_en = 1'b0;
            app_wren = 1'b0;
            go_cmd = !cmd_done && pushed >= pre && app_cmd_rdy;
            go_push = pushed < total && app_data_rdy && (pushed < pre || go_cmd || cmd_done);
            if (go_cmd) begin
                app_cmd_en = 1'b1;
                app_cmd = 3'h0;
                app_addr = addr;
                app_burst_number = 6'(burst);
                cmd_done = 1'b1;
            end
            if (go_push) begin
                app_wren = 1'b1;
                app_data = d[pushed];
                wq.push_back(d[pushed]);
                pushed++;
            end
        end
        @(negedge clk_x1);
        app_cmd_en = 1'b0;
        app_wren = 1'b0;
        if (guard >= 500) timeout_fail("write_issue");
        idx = int'(addr[12:3]);
        for (int j = 0; j <= burst; j++) begin
            if (wq.size() > 0) mem_m[(idx + j) % c_WORDS] = wq.pop_front();
        end
    endtask

    task automatic do_read(input logic [26:0] addr, input int burst,
                           input int wait_beats, output int acc);
        int guard;
        int idx;
        exp_t e;
        cap_q.delete();
        cap_cyc.delete();
        acc = -1;
        guard = 0;
        @(negedge clk_x1);
        while (!app_cmd_rdy && guard < 500) begin
            @(negedge clk_x1);
            guard++;
        end
        if (guard >= 500) begin
            timeout_fail("read_cmd_rdy");
            return;
        end
        app_cmd_en = 1'b1;
        app_cmd = 3'h1;
        app_addr = addr;
        app_burst_number = 6'(burst);
        acc = cyc + 1;
        idx = int'(addr[12:3]);
        for (int j = 0; j <= burst; j++) begin
            e.cyc = acc + c_L + j;
            e.data = mem_m[(idx + j) % c_WORDS];
            exp_q.push_back(e);
        end
        @(negedge clk_x1);
        app_cmd_en = 1'b0;
        guard = 0;
        while (cap_q.size() < wait_beats && guard < 500) begin
            @(negedge clk_x1);
            guard++;
        end
        if (guard >= 500) timeout_fail("read_beats");
    endtask

    task automatic do_other(input logic [2:0] cmd);
        int guard;
        guard = 0;
        @(negedge clk_x1);
        while (!app_cmd_rdy && guard < 500) begin
            @(negedge clk_x1);
            guard++;
        end
        if (guard >= 500) begin
            timeout_fail("other_cmd_rdy");
            return;
        end
        app_cmd_en = 1'b1;
        app_cmd = cmd;
        app_addr = 27'(($urandom & 32'h7FF_FFFF));
        @(negedge clk_x1);
        app_cmd_en = 1'b0;
    endtask

    function automatic logic [26:0] mk_addr(input int idx);
        logic [13:0] hi;
        logic [2:0]  lo;
        hi = 14'($urandom);
        lo = 3'($urandom);
        return {hi, 10'(idx), lo};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] dq [$];
        logic [127:0] lit;
        int acc;
        int guard;
        int op;
        int burst;
        int need;
        int total;
        int k;
        int idx;

        repeat (3) @(negedge clk_x1);
        rst = 1'b0;
        in_reset = 1'b0;
        rel_cyc = cyc;
        repeat (c_CALIB) @(negedge clk_x1);
        chk("calib_lit", init_calib_complete, 1);
        chk("cmd_rdy_lit", app_cmd_rdy, 1);

        // Same-cycle command and data, single beat at address 0.
        lit = 128'h5A0123FA_456789AB_CDEF0123_456789AB;
        dq.delete(); dq.push_back(lit);
        do_write(27'h0, 0, dq, 0);
        do_read(27'h0, 0, 1, acc);
        chk("t2_data", cap_q.size() > 0 ? cap_q[0] : 128'hx, lit);
        chk("t2_latency", cap_cyc.size() > 0 ? 32'(cap_cyc[0] - acc) : 32'hFFFF_FFFF, 4);

        // High address bits alias onto the same word.
        dq.delete(); dq.push_back(128'hAAAA);
        do_write(27'h400_0000, 0, dq, 1);
        dq.delete(); dq.push_back(128'hBBBB);
        do_write(27'h0, 0, dq, 1);
        do_read(27'h400_0000, 0, 1, acc);
        chk("t3_alias", cap_q.size() > 0 ? cap_q[0] : 128'hx, 128'hBBBB);

        // Eight beats queued before the command.
        dq.delete();
        for (int j = 0; j < 8; j++) dq.push_back(128'(j));
        do_write(27'd64 << 3, 7, dq, 8);
        do_read(27'd64 << 3, 7, 8, acc);
        for (int j = 0; j < cap_q.size(); j++) begin
            chk($sformatf("t4_beat%0d", j), cap_q[j], 128'(j));
            chk($sformatf("t4_gap%0d", j), 32'(cap_cyc[j] - cap_cyc[0]), 32'(j));
        end
        chk("t4_count", 32'(cap_q.size()), 8);
        log_idx.push_back(64); log_n.push_back(8);

        // Burst wrapping past the top word.
        dq.delete();
        for (int j = 0; j < 4; j++) dq.push_back(128'h7000 + 128'(j));
        do_write(27'd1023 << 3, 3, dq, 2);
        for (int j = 0; j < 4; j++) begin
            do_read(27'(((1023 + j) % c_WORDS) << 3), 0, 1, acc);
            chk($sformatf("t5_wrap%0d", j), cap_q.size() > 0 ? cap_q[0] : 128'hx,
                128'h7000 + 128'(j));
        end

        // Randomised traffic; leftover beats carry into the next write.
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                burst = $urandom_range(0, 11);
                need = burst + 1 - wq.size();
                if (need < 0) need = 0;
                total = need + ((wq.size() < 4) ? $urandom_range(0, 2) : 0);
                dq.delete();
                for (int j = 0; j < total; j++) dq.push_back(rnd128());
                idx = ($urandom_range(0, 3) == 0) ? $urandom_range(1018, 1023)
                                                  : $urandom_range(0, 1023);
                do_write(mk_addr(idx), burst, dq, $urandom_range(0, total));
                log_idx.push_back(idx); log_n.push_back(burst + 1);
            end else if (op <= 8) begin
                k = $urandom_range(0, log_idx.size() - 1);
                burst = $urandom_range(0, log_n[k] - 1);
                do_read(mk_addr(log_idx[k]), burst, burst + 1, acc);
            end else begin
                do_other(3'($urandom_range(2, 7)));
            end
        end

        // Fill the write FIFO with no command, then overflow it.
        guard = 0;
        while (guard < 100) begin
            @(negedge clk_x1);
            guard++;
            app_wren = 1'b0;
            if (!app_data_rdy) break;
            app_wren = 1'b1;
            app_data = rnd128();
            wq.push_back(app_data);
        end
        app_wren = 1'b0;
        if (guard >= 100) timeout_fail("fifo_fill");
        chk("t6_fifo_level", 32'(wq.size()), 64);
        chk("t6_data_rdy", app_data_rdy, 0);
        app_wren = 1'b1;
        app_data = rnd128();
        ovf_set = 1'b1;
        ovf_cyc = cyc + 1;
        @(negedge clk_x1);
        app_wren = 1'b0;
        chk("t6_overflow", wr_overflow, 1);

        // Reset in the middle of a read burst.
        do_read(27'd64 << 3, 7, 2, acc);
        rst = 1'b1;
        in_reset = 1'b1;
        exp_q.delete();
        wq.delete();
        ovf_set = 1'b0;
        repeat (3) @(negedge clk_x1);
        chk("t6_valid_in_reset", app_rdata_valid, 0);
        rst = 1'b0;
        in_reset = 1'b0;
        rel_cyc = cyc;
        repeat (c_CALIB + 4) @(negedge clk_x1);

        // RAM contents survive reset.
        do_read(27'd64 << 3, 7, 8, acc);
        chk("t6_ram_kept", 32'(cap_q.size()), 8);

        repeat (10) @(negedge clk_x1);
        chk("pending_beats", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
